// File: rtl/heater_pkg.sv
// Shared definitions for heater-ring control blocks: controller state encoding
// and default sizing constants.
package heater_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HEAT  = 2'd2,
    ST_FAULT = 2'd3
  } heater_state_e;

  localparam int unsigned DEF_NUM_RINGS = 8;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_RAMP_STEP = 4;
  localparam int unsigned DEF_TIMEOUT   = 16;

  // Watchdog counter width; covers the full 2..255 timeout range.
  localparam int unsigned WD_W          = 8;

endpackage

// File: rtl/ring_watchdog.sv
// Per-ring liveness watchdog: counts cycles a ring is enabled but not reporting
// running, and holds timeout_o high once the count reaches TIMEOUT.
module ring_watchdog
  import heater_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic running_i,
  output logic timeout_o
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT);

  logic [WD_W-1:0] cnt_q, cnt_d;

  // Saturate at the limit so a stuck ring keeps signalling until it is disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || running_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/ring_heater_ctrl.sv
// Heater ring controller: staggered ring turn-on, PWM heating at a latched
// period/duty, and per-ring watchdogs that latch a fault when a ring stalls.
module ring_heater_ctrl
  import heater_pkg::*;
#(
  parameter int unsigned NUM_RINGS = DEF_NUM_RINGS,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_RINGS-1:0] ring_mask,
  input  logic [CNT_W-1:0]     period,
  input  logic [CNT_W-1:0]     duty,
  input  logic [NUM_RINGS-1:0] running,
  output logic [NUM_RINGS-1:0] enable,
  output logic                 busy,
  output logic                 fault,
  output logic [NUM_RINGS-1:0] fault_mask
);

  localparam int unsigned       STEP_W    = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP - 1);

  heater_state_e        state_q, state_d;
  logic [NUM_RINGS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [CNT_W-1:0]     duty_q, duty_d;
  logic [NUM_RINGS-1:0] pending_q, pending_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [CNT_W-1:0]     pwm_q, pwm_d;
  logic [NUM_RINGS-1:0] enable_q, enable_d;
  logic                 busy_q, busy_d;
  logic                 fault_q, fault_d;
  logic [NUM_RINGS-1:0] fault_mask_q, fault_mask_d;

  logic [NUM_RINGS-1:0] timeout_vec;
  logic [NUM_RINGS-1:0] first_ring;
  logic [NUM_RINGS-1:0] next_ring;
  logic                 start_ok;

  // Two's-complement trick isolates the lowest set bit of each mask.
  assign first_ring = ring_mask & (~ring_mask + NUM_RINGS'(1));
  assign next_ring  = pending_q & (~pending_q + NUM_RINGS'(1));
  assign start_ok   = start && (ring_mask != '0) && (period != '0);

  for (genvar gi = 0; gi < NUM_RINGS; gi++) begin : g_wd
    ring_watchdog #(
      .TIMEOUT (TIMEOUT)
    ) u_wd (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable_i  (enable_q[gi]),
      .running_i (running[gi]),
      .timeout_o (timeout_vec[gi])
    );
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    period_d     = period_q;
    duty_d       = duty_q;
    pending_d    = pending_q;
    step_d       = step_q;
    pwm_d        = pwm_q;
    enable_d     = enable_q;
    busy_d       = busy_q;
    fault_d      = fault_q;
    fault_mask_d = fault_mask_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d   = ST_RAMP;
          mask_d    = ring_mask;
          period_d  = period;
          duty_d    = duty;
          enable_d  = first_ring;
          pending_d = ring_mask & ~first_ring;
          step_d    = '0;
          pwm_d     = '0;
          busy_d    = 1'b1;
        end
      end

      ST_RAMP: begin
        if (timeout_vec != '0) begin
          state_d      = ST_FAULT;
          enable_d     = '0;
          busy_d       = 1'b0;
          fault_d      = 1'b1;
          fault_mask_d = timeout_vec;
        end else if (step_q == STEP_LAST) begin
          step_d = '0;
          if (pending_q != '0) begin
            enable_d  = enable_q | next_ring;
            pending_d = pending_q & ~next_ring;
          end else begin
            // Entry cycle behaves as if the cleared counter had already been compared.
            state_d  = ST_HEAT;
            pwm_d    = '0;
            enable_d = (duty_q != '0) ? mask_q : '0;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      ST_HEAT: begin
        if (timeout_vec != '0) begin
          state_d      = ST_FAULT;
          enable_d     = '0;
          busy_d       = 1'b0;
          fault_d      = 1'b1;
          fault_mask_d = timeout_vec;
        end else begin
          enable_d = (pwm_q < duty_q) ? mask_q : '0;
          pwm_d    = (pwm_q == period_q - CNT_W'(1)) ? '0 : pwm_q + CNT_W'(1);
        end
      end

      ST_FAULT: begin
      end
    endcase

    // Stop overrides everything, including a simultaneous start or timeout.
    if (stop) begin
      state_d      = ST_IDLE;
      pending_d    = '0;
      step_d       = '0;
      pwm_d        = '0;
      enable_d     = '0;
      busy_d       = 1'b0;
      fault_d      = 1'b0;
      fault_mask_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      period_q     <= '0;
      duty_q       <= '0;
      pending_q    <= '0;
      step_q       <= '0;
      pwm_q        <= '0;
      enable_q     <= '0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_mask_q <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      pending_q    <= pending_d;
      step_q       <= step_d;
      pwm_q        <= pwm_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fault_mask_q <= fault_mask_d;
    end
  end

  assign enable     = enable_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_mask = fault_mask_q;

endmodule

// File: tb/tb_ring_heater_ctrl.sv
// Bench for ring_heater_ctrl: start-cycle vector table, directed multi-cycle
// sequences and random runs compared against a closed-form timing model.
module tb_ring_heater_ctrl;
  localparam int NR = 8;
  localparam int CW = 16;
  localparam int RS = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop;
  logic [NR-1:0] ring_mask, running, enable, fault_mask;
  logic [CW-1:0] period, duty;
  logic          busy, fault;
  logic [NR-1:0] dead_rings;

  int total = 0;
  int bad   = 0;

  logic [NR-1:0] cur_mask, cur_dead;
  int            cur_period, cur_duty;

  typedef struct {
    logic          st;
    logic          sp;
    logic [NR-1:0] m;
    int            p;
    int            d;
    logic          e_busy;
    logic [NR-1:0] e_en;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  // Healthy rings report running as soon as they are enabled; dead ones never do.
  assign running = enable & ~dead_rings;

  ring_heater_ctrl #(
    .NUM_RINGS (NR),
    .CNT_W     (CW),
    .RAMP_STEP (RS),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .ring_mask  (ring_mask),
    .period     (period),
    .duty       (duty),
    .running    (running),
    .enable     (enable),
    .busy       (busy),
    .fault      (fault),
    .fault_mask (fault_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int k, input logic [NR-1:0] e_en,
                       input logic e_busy, input logic e_fault, input logic [NR-1:0] e_fm);
    total++;
    if (enable !== e_en || busy !== e_busy || fault !== e_fault || fault_mask !== e_fm) begin
      bad++;
      $display("FAIL %s k=%0d got en=%02h busy=%0b fault=%0b fm=%02h want en=%02h busy=%0b fault=%0b fm=%02h",
               name, k, enable, busy, fault, fault_mask, e_en, e_busy, e_fault, e_fm);
    end
  endtask

  // Expected outputs k cycles after the edge that accepted start, derived from
  // ring order, ramp spacing, PWM phase and the earliest stuck ring's deadline.
  task automatic exp_at(input int k, output logic [NR-1:0] en, output logic b,
                        output logic f, output logic [NR-1:0] fm);
    int j  = 0;
    int kh;
    int kf = 1 << 30;
    int fi = 0;
    en = '0;
    for (int i = 0; i < NR; i++) begin
      if (cur_mask[i]) begin
        int r;
        r = 1 + j * RS;
        if (k >= r) en[i] = 1'b1;
        if (cur_dead[i] && (r + TO + 1) < kf) begin
          kf = r + TO + 1;
          fi = i;
        end
        j++;
      end
    end
    kh = 1 + j * RS;
    if (k >= kh) begin
      if (k == kh) en = (cur_duty != 0) ? cur_mask : '0;
      else         en = (((k - kh - 1) % cur_period) < cur_duty) ? cur_mask : '0;
    end
    b  = 1'b1;
    f  = 1'b0;
    fm = '0;
    if (k >= kf) begin
      en     = '0;
      b      = 1'b0;
      f      = 1'b1;
      fm[fi] = 1'b1;
    end
  endtask

  task automatic begin_run(input logic [NR-1:0] m, input int p, input int d, input logic [NR-1:0] dd);
    cur_mask   = m;
    cur_period = p;
    cur_duty   = d;
    cur_dead   = dd;
    dead_rings = dd;
    ring_mask  = m;
    period     = CW'(p);
    duty       = CW'(d);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Inputs are scrambled every cycle: only the start-cycle values may matter.
  task automatic check_span(input string name, input int k0, input int k1);
    logic [NR-1:0] e_en, e_fm;
    logic          e_b, e_f;
    for (int k = k0; k <= k1; k++) begin
      exp_at(k, e_en, e_b, e_f, e_fm);
      check(name, k, e_en, e_b, e_f, e_fm);
      ring_mask = NR'($urandom);
      period    = CW'($urandom);
      duty      = CW'($urandom);
      tick();
    end
  endtask

  task automatic stop_and_check(input string name);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check(name, 0, '0, 1'b0, 1'b0, '0);
    tick();
    check(name, 1, '0, 1'b0, 1'b0, '0);
    dead_rings = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    ring_mask  = '0;
    period     = '0;
    duty       = '0;
    dead_rings = '0;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 10, 4, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h05,  0, 4, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 8'h05, 10, 4, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 8'h05, 10, 4, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h05, 10, 4, 1'b1, 8'h01};
    vecs[5] = '{1'b1, 1'b0, 8'h80,  1, 0, 1'b1, 8'h80};
    vecs[6] = '{1'b1, 1'b0, 8'h06,  3, 2, 1'b1, 8'h02};

    #12;
    check("reset", 0, '0, 1'b0, 1'b0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset", 0, '0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 7; i++) begin
      ring_mask = vecs[i].m;
      period    = CW'(vecs[i].p);
      duty      = CW'(vecs[i].d);
      start     = vecs[i].st;
      stop      = vecs[i].sp;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check($sformatf("vec%0d", i), 1, vecs[i].e_en, vecs[i].e_busy, 1'b0, '0);
      stop_and_check($sformatf("vec%0d_stop", i));
      $display("vector %0d start=%0b stop=%0b mask=%02h period=%0d bad=%0d",
               i, vecs[i].st, vecs[i].sp, vecs[i].m, vecs[i].p, bad);
    end

    begin_run(8'h05, 10, 4, '0);
    check_span("ramp_pwm", 1, 34);
    stop_and_check("ramp_pwm_stop");
    $display("seq ramp_pwm mask=05 period=10 duty=4 bad=%0d", bad);

    begin_run(8'hFF, 8, 8, '0);
    check_span("all_on", 1, 50);
    stop_and_check("all_on_stop");
    $display("seq all_on mask=ff period=8 duty=8 bad=%0d", bad);

    begin_run(8'h01, 8, 8, 8'h01);
    check_span("stuck_ring", 1, 22);
    stop_and_check("stuck_ring_stop");
    $display("seq stuck_ring mask=01 dead=01 bad=%0d", bad);

    begin_run(8'h01, 6, 6, 8'h01);
    check_span("stop_vs_timeout", 1, 16);
    stop_and_check("stop_vs_timeout_stop");
    $display("seq stop_vs_timeout bad=%0d", bad);

    begin_run(8'h05, 10, 4, '0);
    check_span("heat", 1, 15);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (enable !== '0 || busy !== 1'b0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got en=%02h busy=%0b fault=%0b want en=00 busy=0 fault=0",
               enable, busy, fault);
    end
    tick();
    rst_n = 1'b1;
    tick();
    check("post_async_rst", 0, '0, 1'b0, 1'b0, '0);
    begin_run(8'h05, 10, 4, '0);
    check_span("restart", 1, 14);
    stop_and_check("restart_stop");
    $display("seq async_reset_restart bad=%0d", bad);

    for (int it = 0; it < 24; it++) begin
      logic [NR-1:0] m, dd;
      int p, d, n, kend;
      m  = NR'($urandom_range(1, 255));
      p  = $urandom_range(1, 12);
      d  = $urandom_range(0, 14);
      dd = '0;
      if (it % 3 == 2) begin
        dd = m & NR'($urandom);
        d  = p + $urandom_range(0, 3);
      end
      n    = $countones(m);
      kend = (dd != '0) ? (n * RS + TO + 8) : (1 + n * RS + 2 * p + 4);
      begin_run(m, p, d, dd);
      check_span("rand", 1, kend);
      stop_and_check("rand_stop");
      $display("run %0d mask=%02h period=%0d duty=%0d dead=%02h cycles=%0d bad=%0d",
               it, m, p, d, dd, kend, bad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_heater_ctrl.md
RING_HEATER_CTRL -- requirements
Module: ring_heater_ctrl

Interface
REQ-001 Parameter NUM_RINGS, default 8, number of heater ring oscillators driven.
REQ-002 Parameter CNT_W, default 16, width of period/duty counters.
REQ-003 Parameter RAMP_STEP, default 4, cycles between successive ring enables during ramp (>=1).
REQ-004 Parameter TIMEOUT, default 16, cycles an enabled ring may show running=0 before fault (2..255).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle request to begin heating; honoured only in IDLE.
REQ-008 stop  in  1  single-cycle request to abort/clear; honoured in every state.
REQ-009 ring_mask  in  NUM_RINGS  rings to use; sampled with start.
REQ-010 period  in  CNT_W  PWM period in cycles; sampled with start.
REQ-011 duty  in  CNT_W  PWM on-cycles per period; sampled with start.
REQ-012 running  in  NUM_RINGS  per-ring status returned by each heater ring.
REQ-013 enable  out  NUM_RINGS  per-ring enable to heater rings, registered.
REQ-014 busy  out  1  high in RAMP and HEAT.
REQ-015 fault  out  1  high in FAULT.
REQ-016 fault_mask  out  NUM_RINGS  rings that caused the fault, sticky until stop.

Function
REQ-017 FSM states IDLE, RAMP, HEAT, FAULT; all outputs registered.
REQ-018 IDLE: start=1, stop=0, ring_mask!=0, period!=0 -> latch mask/period/duty, enter RAMP; otherwise start ignored, remain IDLE.
REQ-019 RAMP: lowest-index unlatched masked ring's enable asserts the cycle after start is sampled; each further masked ring (ascending index) asserts RAMP_STEP cycles after the previous.
REQ-020 RAMP -> HEAT RAMP_STEP cycles after the last masked ring asserts; PWM counter cleared to 0 on entry.
REQ-021 HEAT: counter runs 0..period-1, wrap to 0; enable = latched mask when counter < duty, else 0 (registered, one-cycle lag vs counter).
REQ-022 duty >= period -> enable continuously = mask; duty = 0 -> enable continuously 0; no faults possible when 0.
REQ-023 Unsigned CNT_W compare; no overflow since counter < period <= 2^CNT_W-1.
REQ-024 Per-ring watchdog: counter increments while enable[i]=1 and running[i]=0; clears when enable[i]=0 or running[i]=1.
REQ-025 Watchdog for ring i reaching TIMEOUT in RAMP or HEAT -> FAULT next cycle; fault_mask gets every ring reaching TIMEOUT that cycle.
REQ-026 Entering FAULT: enable all 0, busy 0, fault 1 on the same edge as the state change.
REQ-027 FAULT: start ignored; stop -> IDLE, fault 0, fault_mask cleared.
REQ-028 stop in RAMP or HEAT -> IDLE next edge, enable all 0, watchdogs cleared.
REQ-029 start and stop in the same cycle: stop wins.
REQ-030 Watchdog timeout and stop in the same cycle: stop wins, no fault recorded.
REQ-031 Input changes to ring_mask/period/duty outside the start cycle have no effect.

Reset
REQ-032 rst_n low: immediately state IDLE, enable 0, busy 0, fault 0, fault_mask 0, all counters/latched values 0.
REQ-033 rst_n asserted mid-RAMP/HEAT: enables drop asynchronously; after release, block idles until a new start.

Structure
REQ-034 Shared package heater_pkg holds state encoding and default parameter constants, reused by heater-ring modules.
REQ-035 One sub-module ring_watchdog (one instance per ring): enable, running in; timeout pulse out; TIMEOUT parameter.

Verification
REQ-036 mask=8'b0000_0101, period=10, duty=4, RAMP_STEP=4, running follows enable -> enable[0] at start+1, enable[2] at start+5, HEAT at start+9, then 4 on/6 off repeating.
REQ-037 mask=8'hFF, duty=period=8 -> all rings on continuously after ramp, busy=1, fault never asserts.
REQ-038 mask=8'h01, running[0] held 0, TIMEOUT=16 -> fault=1, fault_mask=8'h01, enable=0 at 17th cycle after enable[0] rises; stop -> IDLE, fault_mask=0.
REQ-039 start with mask=0 or period=0 -> stays IDLE, busy=0, enable=0.
REQ-040 start and stop same cycle in IDLE, and stop mid-HEAT -> IDLE, enable 0 next cycle, no fault.
REQ-041 rst_n pulsed low mid-HEAT -> enable 0 asynchronously; second start after release ramps from ring 0 again.
